// File: rtl/irda_mir_destuff_pkg.sv
// Shared definitions for the MIR receive de-stuffer.
// Holds the two-state framing FSM encoding, the HDLC run-length thresholds
// and the CRC-16-CCITT (reflected) constants plus a one-bit CRC step helper.
package irda_mir_destuff_pkg;

    typedef enum logic [0:0] {
        StHunt    = 1'b0,
        StInFrame = 1'b1
    } mdb_state_e;

    localparam logic [15:0] MdbCrcPoly    = 16'h8408;
    localparam logic [15:0] MdbCrcInit    = 16'hFFFF;
    localparam logic [15:0] MdbCrcResidue = 16'hF0B8;

    localparam logic [2:0] MdbAbortOnes = 3'd7;
    localparam logic [2:0] MdbStuffOnes = 3'd5;

    // One step of the LSB-first (reflected) serial CRC.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? MdbCrcPoly : 16'h0000);
    endfunction

endpackage

// File: rtl/irda_mir_destuff_if.sv
// Bus between the MIR flag detector / receive controller and the de-stuffer.
// slave  : de-stuffer side (consumes std_* and mdb_restart, drives mdb_* results)
// master : environment side (drives std_*, mir_rxbit_enable, mdb_restart)
interface irda_mir_destuff_if #(
    parameter int unsigned BYTE_CNT_W = 12
);
    logic                  mir_rxbit_enable;
    logic                  std_o;
    logic                  std_is_good_bit;
    logic                  std_st_detected;
    logic                  mdb_restart;
    logic [7:0]            mdb_byte_o;
    logic                  mdb_byte_valid;
    logic                  mdb_frame_start;
    logic                  mdb_frame_end;
    logic                  mdb_abort;
    logic [BYTE_CNT_W-1:0] mdb_byte_cnt;
    logic                  mdb_crc_ok;

    modport master (
        output mir_rxbit_enable, std_o, std_is_good_bit, std_st_detected, mdb_restart,
        input  mdb_byte_o, mdb_byte_valid, mdb_frame_start, mdb_frame_end, mdb_abort,
               mdb_byte_cnt, mdb_crc_ok
    );

    modport slave (
        input  mir_rxbit_enable, std_o, std_is_good_bit, std_st_detected, mdb_restart,
        output mdb_byte_o, mdb_byte_valid, mdb_frame_start, mdb_frame_end, mdb_abort,
               mdb_byte_cnt, mdb_crc_ok
    );
endinterface

// File: rtl/irda_mir_crc16.sv
// Serial reflected CRC-16-CCITT (poly 0x8408, init 0xFFFF).
// Ports: clk, wb_rst_i (async, active high), init (reload init value),
//        bit_en (advance by bit_i), bit_i, crc_o (current register).
// init has priority over bit_en.
module irda_mir_crc16
    import irda_mir_destuff_pkg::*;
(
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        init,
    input  logic        bit_en,
    input  logic        bit_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = MdbCrcInit;
        end else if (bit_en) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            crc_q <= MdbCrcInit;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/irda_mir_destuff.sv
// MIR receive de-stuffer: sits after the STA/STO flag detector, drops HDLC
// stuffed zeros, detects aborts, assembles LSB-first bytes and marks frame
// start/end for the receive FIFO/DMA.
// Ports: clk, wb_rst_i (async, active high), mdb (irda_mir_destuff_if.slave):
//   inputs  mir_rxbit_enable, std_o, std_is_good_bit, std_st_detected, mdb_restart
//   outputs mdb_byte_o, mdb_byte_valid, mdb_frame_start, mdb_frame_end, mdb_abort,
//           mdb_byte_cnt, mdb_crc_ok
// Optional FCS check: define IRDA_MIR_DESTUFF_CRC_EN; otherwise mdb_crc_ok is tied high.
module irda_mir_destuff
    import irda_mir_destuff_pkg::*;
#(
    parameter int unsigned MIN_FRAME_BYTES = 1,
    parameter int unsigned BYTE_CNT_W      = 12
) (
    input logic               clk,
    input logic               wb_rst_i,
    irda_mir_destuff_if.slave mdb
);
    localparam logic [BYTE_CNT_W-1:0] MinBytes = BYTE_CNT_W'(MIN_FRAME_BYTES);

    mdb_state_e            state_q, state_d;
    logic [2:0]            ones_q, ones_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            sh_q, sh_d;
    logic [7:0]            byte_q, byte_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  seen_q, seen_d;   // a byte has completed since the last flag
    logic                  valid_q, valid_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;
    logic                  abort_q, abort_d;
    logic                  shift_en;
    logic                  flag_ev, data_ev;
    logic [BYTE_CNT_W-1:0] frame_bytes;

    assign flag_ev = mdb.mir_rxbit_enable & mdb.std_st_detected;
    assign data_ev = mdb.mir_rxbit_enable & mdb.std_is_good_bit & ~mdb.std_st_detected;
    // byte_cnt_q still shows the previous frame until this frame's first byte lands.
    assign frame_bytes = seen_q ? byte_cnt_q : '0;

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        byte_d     = byte_q;
        byte_cnt_d = byte_cnt_q;
        seen_d     = seen_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        abort_d    = 1'b0;
        shift_en   = 1'b0;

        if (mdb.mdb_restart) begin
            state_d    = StHunt;
            ones_d     = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            seen_d     = 1'b0;
        end else if (flag_ev) begin
            // A closing flag is also the next opening flag.
            if (state_q == StInFrame) begin
                if (bit_cnt_q != '0) begin
                    abort_d = 1'b1;
                end else if (frame_bytes >= MinBytes) begin
                    end_d = 1'b1;
                end
            end
            state_d   = StInFrame;
            ones_d    = '0;
            bit_cnt_d = '0;
            seen_d    = 1'b0;
        end else if (data_ev && state_q == StInFrame) begin
            if (mdb.std_o) begin
                if (ones_q == MdbAbortOnes - 3'd1) begin
                    abort_d   = 1'b1;
                    state_d   = StHunt;
                    ones_d    = '0;
                    bit_cnt_d = '0;
                end else begin
                    ones_d   = ones_q + 3'd1;
                    shift_en = 1'b1;
                end
            end else begin
                ones_d   = '0;
                shift_en = (ones_q != MdbStuffOnes);  // zero after five ones is stuffing
            end
        end

        if (shift_en) begin
            sh_d = {mdb.std_o, sh_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = '0;
                byte_d    = {mdb.std_o, sh_q[7:1]};
                valid_d   = 1'b1;
                if (!seen_q) begin
                    seen_d     = 1'b1;
                    start_d    = 1'b1;
                    byte_cnt_d = BYTE_CNT_W'(1);
                end else if (byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StHunt;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            byte_q     <= '0;
            byte_cnt_q <= '0;
            seen_q     <= 1'b0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            byte_q     <= byte_d;
            byte_cnt_q <= byte_cnt_d;
            seen_q     <= seen_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
            abort_q    <= abort_d;
        end
    end

    assign mdb.mdb_byte_o      = byte_q;
    assign mdb.mdb_byte_valid  = valid_q;
    assign mdb.mdb_frame_start = start_q;
    assign mdb.mdb_frame_end   = end_q;
    assign mdb.mdb_abort       = abort_q;
    assign mdb.mdb_byte_cnt    = byte_cnt_q;

`ifdef IRDA_MIR_DESTUFF_CRC_EN
    logic [15:0] crc;
    logic        crc_init;
    logic        crc_ok_q, crc_ok_d;

    assign crc_init = mdb.mdb_restart | flag_ev;

    irda_mir_crc16 u_crc16 (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .init     (crc_init),
        .bit_en   (shift_en),
        .bit_i    (mdb.std_o),
        .crc_o    (crc)
    );

    always_comb begin
        crc_ok_d = crc_ok_q;
        if (end_d) begin
            crc_ok_d = (crc == MdbCrcResidue);
        end else if (abort_d) begin
            crc_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            crc_ok_q <= 1'b0;
        end else begin
            crc_ok_q <= crc_ok_d;
        end
    end

    assign mdb.mdb_crc_ok = crc_ok_q;
`else
    assign mdb.mdb_crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_irda_mir_destuff.sv
module tb_irda_mir_destuff;
    localparam int unsigned CntW = 12;
`ifdef IRDA_MIR_DESTUFF_CRC_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 clk = ~clk;

    irda_mir_destuff_if #(.BYTE_CNT_W(CntW)) bus ();

    irda_mir_destuff #(
        .MIN_FRAME_BYTES (1),
        .BYTE_CNT_W      (CntW)
    ) dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .mdb      (bus)
    );

    typedef enum int {EvByte, EvEnd, EvAbort} ev_kind_e;
    typedef struct {
        ev_kind_e        kind;
        logic [7:0]      data;
        logic            start;
        logic            crc_ok;
        logic [CntW-1:0] cnt;
    } ev_t;

    ev_t             exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              stuff_ones = 0;
    logic            first_in_frame = 1'b1;
    logic [CntW-1:0] exp_cnt = '0;
    logic [15:0]     model_crc = 16'hFFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    ev_t got;
    always @(negedge clk) begin
        if (!wb_rst_i && (bus.mdb_byte_valid || bus.mdb_frame_end || bus.mdb_abort
                          || bus.mdb_frame_start)) begin
            chk("pulse_exclusive",
                $countones({bus.mdb_byte_valid, bus.mdb_frame_end, bus.mdb_abort}), 1);
            chk("start_without_byte", {31'd0, bus.mdb_frame_start & ~bus.mdb_byte_valid}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse",
                    {29'd0, bus.mdb_byte_valid, bus.mdb_frame_end, bus.mdb_abort}, 0);
            end else begin
                got = exp_q.pop_front();
                chk("kind_byte",  {31'd0, bus.mdb_byte_valid}, {31'd0, got.kind == EvByte});
                chk("kind_end",   {31'd0, bus.mdb_frame_end},  {31'd0, got.kind == EvEnd});
                chk("kind_abort", {31'd0, bus.mdb_abort},      {31'd0, got.kind == EvAbort});
                if (got.kind == EvByte) begin
                    chk("byte_data",   {24'd0, bus.mdb_byte_o}, {24'd0, got.data});
                    chk("frame_start", {31'd0, bus.mdb_frame_start}, {31'd0, got.start});
                    chk("byte_cnt",    {20'd0, bus.mdb_byte_cnt}, {20'd0, got.cnt});
                end else if (got.kind == EvEnd) begin
                    chk("end_cnt",    {20'd0, bus.mdb_byte_cnt}, {20'd0, got.cnt});
                    chk("end_crc_ok", {31'd0, bus.mdb_crc_ok}, {31'd0, got.crc_ok});
                end
            end
        end
    end

    // One MIR bit period: enable for one clk, then nine idle clks.
    task automatic step(input logic flag, input logic good, input logic b, input logic rs);
        @(negedge clk);
        bus.mir_rxbit_enable = 1'b1;
        bus.std_st_detected  = flag;
        bus.std_is_good_bit  = good;
        bus.std_o            = b;
        bus.mdb_restart      = rs;
        @(negedge clk);
        bus.mir_rxbit_enable = 1'b0;
        bus.std_st_detected  = 1'b0;
        bus.std_is_good_bit  = 1'b0;
        bus.std_o            = 1'b0;
        bus.mdb_restart      = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_flag();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        stuff_ones     = 0;
        first_in_frame = 1'b1;
        model_crc      = 16'hFFFF;
    endtask

    task automatic raw_bit(input logic b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    // Payload bit with transmitter-side zero stuffing and a reference CRC.
    task automatic send_bit(input logic b);
        model_crc = (model_crc >> 1) ^ (((model_crc[0] ^ b) == 1'b1) ? 16'h8408 : 16'h0000);
        raw_bit(b);
        if (b) begin
            stuff_ones++;
            if (stuff_ones == 5) begin
                raw_bit(1'b0);
                stuff_ones = 0;
            end
        end else begin
            stuff_ones = 0;
        end
    endtask

    task automatic expect_byte(input logic [7:0] d);
        ev_t e;
        exp_cnt = first_in_frame ? CntW'(1) : exp_cnt + 1'b1;
        e = '{kind: EvByte, data: d, start: first_in_frame, crc_ok: 1'b0, cnt: exp_cnt};
        exp_q.push_back(e);
        first_in_frame = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        expect_byte(d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic expect_end();
        ev_t e;
        e = '{kind: EvEnd, data: 8'h00, start: 1'b0,
              crc_ok: CrcEn ? (model_crc == 16'hF0B8) : 1'b1, cnt: exp_cnt};
        exp_q.push_back(e);
    endtask

    task automatic expect_abort();
        ev_t e;
        e = '{kind: EvAbort, data: 8'h00, start: 1'b0, crc_ok: 1'b0, cnt: '0};
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_o"},  {24'd0, bus.mdb_byte_o}, 0);
        chk({tag, "_valid"},   {31'd0, bus.mdb_byte_valid}, 0);
        chk({tag, "_start"},   {31'd0, bus.mdb_frame_start}, 0);
        chk({tag, "_end"},     {31'd0, bus.mdb_frame_end}, 0);
        chk({tag, "_abort"},   {31'd0, bus.mdb_abort}, 0);
        chk({tag, "_cnt"},     {20'd0, bus.mdb_byte_cnt}, 0);
        chk({tag, "_crc_ok"},  {31'd0, bus.mdb_crc_ok}, CrcEn ? 0 : 1);
    endtask

    logic [7:0] msg[11];
    logic [7:0] sb;

    initial begin
        bus.mir_rxbit_enable = 1'b0;
        bus.std_o            = 1'b0;
        bus.std_is_good_bit  = 1'b0;
        bus.std_st_detected  = 1'b0;
        bus.mdb_restart      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        wb_rst_i = 1'b0;

        // 1: two unstuffed bytes
        send_flag();
        send_byte(8'h55);
        send_byte(8'hA3);
        expect_end();
        send_flag();
        chk("t1_cnt", {20'd0, bus.mdb_byte_cnt}, 2);

        // 2: 0xFF needs one stuffed zero; back-to-back flag first gives no pulse
        send_flag();
        send_byte(8'hFF);
        expect_end();
        send_flag();
        chk("t2_cnt", {20'd0, bus.mdb_byte_cnt}, 1);

        // 3: flag mid-byte aborts, then a normal frame
        raw_bit(1'b1);
        raw_bit(1'b0);
        raw_bit(1'b1);
        expect_abort();
        send_flag();
        chk("t3_crc_after_abort", {31'd0, bus.mdb_crc_ok}, CrcEn ? 0 : 1);
        send_byte(8'h12);
        expect_end();
        send_flag();
        chk("t3_cnt", {20'd0, bus.mdb_byte_cnt}, 1);

        // 4: seven ones abort and drop to HUNT; following bits ignored
        send_byte(8'h01);
        for (int i = 0; i < 6; i++) raw_bit(1'b1);
        expect_abort();
        raw_bit(1'b1);
        sb = 8'h12;
        for (int i = 0; i < 8; i++) raw_bit(sb[i]);
        send_flag();
        chk("t4_cnt", {20'd0, bus.mdb_byte_cnt}, 1);

        // 5: "123456789" + FCS, then the same with one corrupted byte
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        for (int i = 0; i < 11; i++) send_byte(msg[i]);
        expect_end();
        send_flag();
        chk("t5_good_crc_ok", {31'd0, bus.mdb_crc_ok}, 1);
        chk("t5_cnt", {20'd0, bus.mdb_byte_cnt}, 11);
        msg[4] = 8'h34;
        for (int i = 0; i < 11; i++) send_byte(msg[i]);
        expect_end();
        send_flag();
        chk("t5_bad_crc_ok", {31'd0, bus.mdb_crc_ok}, CrcEn ? 0 : 1);

        // 6a: restart together with the 8th bit
        sb = 8'h5A;
        for (int i = 0; i < 7; i++) send_bit(sb[i]);
        step(1'b0, 1'b1, sb[7], 1'b1);
        chk("t6_restart_cnt", {20'd0, bus.mdb_byte_cnt}, 0);
        exp_cnt = '0;

        // 6b: async reset mid-byte clears outputs before any clock edge
        send_flag();
        for (int i = 0; i < 4; i++) raw_bit(1'b1);
        @(negedge clk);
        #2 wb_rst_i = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        wb_rst_i = 1'b0;
        send_flag();
        send_flag();
        send_byte(8'hC3);
        expect_end();
        send_flag();
        chk("t6_cnt", {20'd0, bus.mdb_byte_cnt}, 1);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
